hilo_muldiv: RTL and testbench
==============================

Name: hilo_muldiv

Overview:
Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath.
- Sits directly downstream of the register file.
- Consumes both register-file read ports (rs, rt) for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Supplies HI/LO to the writeback mux for MFHI/MFLO.
- Runs one radix-2 iteration per cycle, so the main pipeline must stall on busy.

Parameters:
WIDTH, 32, operand and HI/LO width (only 32 is verified)

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  launch the operation selected by op; sampled only when busy=0
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
rs_data  input  WIDTH  operand A / dividend (register-file readData1)
rt_data  input  WIDTH  operand B / divisor (register-file readData2)
mthi  input  1  write rs_data into HI
mtlo  input  1  write rs_data into LO
busy  output  1  operation in flight; pipeline must stall
done  output  1  one-cycle pulse, HI/LO just updated
div_by_zero  output  1  one-cycle pulse alongside done when the divisor was 0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0; counter and operand latches=0. Asserting reset mid-operation aborts it; HI/LO are not updated and no done pulse is produced.
- FSM states: IDLE, CALC, FIX.
- IDLE, start=1 at edge T0:
  - latch op, sign flags and |rs|, |rt|; absolute value is taken only for signed ops, so |0x80000000| = 0x80000000 unsigned.
  - busy becomes 1 and counter is cleared; go to CALC.
  - DIV/DIVU with rt_data=0: go directly to FIX.
- CALC: one shift-add (multiply) or restoring-subtract (divide) step per edge, T1..T32. Counter is 5-bit; exit to FIX when the counter wraps from 31.
- FIX, edge T33 (T1 for divide-by-zero):
  - apply sign correction and write HI/LO.
  - busy becomes 0, done becomes 1 for exactly one cycle; go to IDLE.
- Latency: 33 cycles from accept to HI/LO valid (1 cycle for divide-by-zero). busy is high for edges T0..T32 inclusive.
- Multiply: 64-bit product, HI=upper, LO=lower. For MULT, negate the full 64 bits when sign(A)^sign(B).
- Divide: LO=quotient, HI=remainder.
  - For DIV, quotient is negated if sign(A)^sign(B); remainder takes sign(A), truncating toward zero.
  - Divide-by-zero: LO=32'hFFFF_FFFF, HI=rs_data, div_by_zero pulses with done.
  - DIV 0x80000000 / -1: LO=0x80000000, HI=0, no flag.
- HI/LO hold their values throughout busy and change only at FIX or on MTHI/MTLO.
- start, mthi and mtlo are ignored while busy=1; no queueing.
- MTHI/MTLO in IDLE write on the same edge; both may be asserted together.
- Simultaneous start with mthi/mtlo in IDLE: start wins and the move is dropped.
- done and start may coincide only in the cycle after FIX (state=IDLE): a new start is accepted there.

Decomposition:
- Shared package: op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), FSM state enum, WIDTH constant, DIV0_QUOTIENT constant (all ones).
- One sub-module, muldiv_step: a purely combinational single iteration that takes the accumulator/remainder, multiplicand/divisor and mode and returns the next accumulator and quotient bit. The top holds the FSM, counter, sign logic and HI/LO.

Test Plan:
- MULT rs=7, rt=-3 -> done exactly 33 cycles after accept; HI=FFFFFFFF, LO=FFFFFFEB; busy high for 33 cycles.
- MULTU rs=FFFFFFFF, rt=FFFFFFFF -> HI=FFFFFFFE, LO=00000001; MULT with same operands -> HI=0, LO=1.
- DIV rs=-7, rt=2 -> LO=FFFFFFFD, HI=FFFFFFFF; DIVU rs=7, rt=2 -> LO=3, HI=1; DIV 80000000 / FFFFFFFF -> LO=80000000, HI=0.
- DIVU rs=100, rt=0 -> done and div_by_zero one cycle after accept; LO=FFFFFFFF, HI=100.
- During a MULT: start (DIV), mthi and mtlo pulses -> all ignored; final HI/LO equal the MULT result; MTHI 0x1234 after done -> hi=0x1234, lo unchanged.
- Pulse rst_n low at cycle 10 of a DIV -> busy=0, hi=lo=0 immediately, no done; a new MULT 2*3 then gives LO=6, HI=0.

Source files
------------

// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation codes,
// FSM states and the constants used when building results.
package hilo_muldiv_pkg;

    localparam int WIDTH = 32;
    localparam logic [WIDTH-1:0] DIV0_QUOTIENT = '1;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } mdState_t;

    function automatic logic isSignedOp(input logic [1:0] opCode);
        return (opCode == OP_MULT) || (opCode == OP_DIV);
    endfunction

    function automatic logic isDivOp(input logic [1:0] opCode);
        return (opCode == OP_DIV) || (opCode == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring subtract for divide.
// Purely combinational; the caller owns the shifting of the low word.
module muldiv_step #(
    parameter int WIDTH = hilo_muldiv_pkg::WIDTH
) (
    input  logic             isDiv,
    input  logic [WIDTH-1:0] accIn,
    input  logic             inBit,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] accOut,
    output logic             qBit
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;

    always_comb begin
        sum     = {1'b0, accIn} + (inBit ? {1'b0, operand} : '0);
        shifted = {accIn, inBit};
        accOut  = '0;
        qBit    = 1'b0;
        if (isDiv) begin
            // Difference is below the divisor, so the low WIDTH bits are exact.
            if (shifted >= {1'b0, operand}) begin
                accOut = shifted[WIDTH-1:0] - operand;
                qBit   = 1'b1;
            end else begin
                accOut = shifted[WIDTH-1:0];
                qBit   = 1'b0;
            end
        end else begin
            // qBit is the bit that shifts into the top of the multiplier word.
            accOut = sum[WIDTH:1];
            qBit   = sum[0];
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Operands are made non-negative on accept, iterated 32 times, then sign-fixed.
//
// state | meaning
// IDLE  | waiting; accepts start or MTHI/MTLO moves
// CALC  | one multiply/divide iteration per clock
// FIX   | sign correction, HI/LO write, done pulse
import hilo_muldiv_pkg::*;

module hilo_muldiv #(
    parameter int WIDTH = hilo_muldiv_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    mdState_t         state;
    logic [1:0]       opReg;
    logic             signA;
    logic             signB;
    logic             divZero;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] accHi;
    logic [WIDTH-1:0] accLo;
    logic [WIDTH-1:0] operandB;

    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;
    logic             stepIn;
    logic [WIDTH-1:0] stepAcc;
    logic             stepBit;
    logic             negProd;
    logic             negQuot;
    logic             negRem;

    // Absolute value only for signed ops; 0x80000000 maps to itself.
    assign absA = (isSignedOp(op) && rs_data[WIDTH-1]) ? -rs_data : rs_data;
    assign absB = (isSignedOp(op) && rt_data[WIDTH-1]) ? -rt_data : rt_data;

    assign stepIn  = isDivOp(opReg) ? accLo[WIDTH-1] : accLo[0];
    assign negProd = isSignedOp(opReg) && (signA ^ signB);
    assign negQuot = negProd;
    assign negRem  = isSignedOp(opReg) && signA;

    muldiv_step #(.WIDTH(WIDTH)) uStep (
        .isDiv   (isDivOp(opReg)),
        .accIn   (accHi),
        .inBit   (stepIn),
        .operand (operandB),
        .accOut  (stepAcc),
        .qBit    (stepBit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            opReg       <= '0;
            signA       <= 1'b0;
            signB       <= 1'b0;
            divZero     <= 1'b0;
            cnt         <= '0;
            accHi       <= '0;
            accLo       <= '0;
            operandB    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        opReg    <= op;
                        signA    <= rs_data[WIDTH-1];
                        signB    <= rt_data[WIDTH-1];
                        cnt      <= '0;
                        accHi    <= '0;
                        accLo    <= absA;
                        operandB <= absB;
                        busy     <= 1'b1;
                        if (isDivOp(op) && (rt_data == '0)) begin
                            // Raw dividend parked in accHi becomes HI.
                            divZero <= 1'b1;
                            accHi   <= rs_data;
                            state   <= FIX;
                        end else begin
                            divZero <= 1'b0;
                            state   <= CALC;
                        end
                    end else begin
                        if (mthi) hi <= rs_data;
                        if (mtlo) lo <= rs_data;
                    end
                end
                CALC: begin
                    accHi <= stepAcc;
                    accLo <= isDivOp(opReg) ? {accLo[WIDTH-2:0], stepBit}
                                            : {stepBit, accLo[WIDTH-1:1]};
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_STEP) state <= FIX;
                end
                FIX: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                    if (divZero) begin
                        hi          <= accHi;
                        lo          <= DIV0_QUOTIENT[WIDTH-1:0];
                        div_by_zero <= 1'b1;
                    end else if (isDivOp(opReg)) begin
                        lo <= negQuot ? -accLo : accLo;
                        hi <= negRem  ? -accHi : accHi;
                    end else begin
                        {hi, lo} <= negProd ? -{accHi, accLo} : {accHi, accLo};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Bench for hilo_muldiv: an arithmetic reference model checked every cycle,
// plus directed operations with hand-computed HI/LO, latency and busy length.
module tb_hilo_muldiv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int nCompared = 0;
    int nMismatched = 0;

    hilo_muldiv #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of one operation, straight from the arithmetic rules.
    task automatic refResult(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] h, output logic [31:0] l, output logic dz);
        longint     sp;
        logic [63:0] up;
        int         sa;
        int         sb;
        dz = 1'b0;
        h  = '0;
        l  = '0;
        case (o)
            2'b00: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                {h, l} = 64'(sp);
            end
            2'b01: begin
                up = {32'b0, a} * {32'b0, b};
                {h, l} = up;
            end
            default: begin
                if (b == 32'd0) begin
                    h  = a;
                    l  = 32'hFFFF_FFFF;
                    dz = 1'b1;
                end else if (o == 2'b11) begin
                    l = a / b;
                    h = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    l = 32'h8000_0000;
                    h = 32'h0;
                end else begin
                    sa = a;
                    sb = b;
                    l  = 32'(sa / sb);
                    h  = 32'(sa % sb);
                end
            end
        endcase
    endtask

    // Reference model: an op in flight for a fixed number of clocks, result applied at the end.
    int unsigned remCyc = 0;
    logic [31:0] mHi = '0, mLo = '0, pHi = '0, pLo = '0;
    logic        mDone = 1'b0, mDz = 1'b0, pDz = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remCyc = 0;
            mHi    = '0;
            mLo    = '0;
            mDone  = 1'b0;
            mDz    = 1'b0;
        end else begin
            mDone = 1'b0;
            mDz   = 1'b0;
            if (remCyc != 0) begin
                remCyc--;
                if (remCyc == 0) begin
                    mHi   = pHi;
                    mLo   = pLo;
                    mDone = 1'b1;
                    mDz   = pDz;
                end
            end else if (start) begin
                refResult(op, rs_data, rt_data, pHi, pLo, pDz);
                remCyc = (op[1] && rt_data == 32'd0) ? 1 : 33;
            end else begin
                if (mthi) mHi = rs_data;
                if (mtlo) mLo = rs_data;
            end
        end
    end

    always @(negedge clk) begin
        check("busy", busy, remCyc != 0);
        check("done", done, mDone);
        check("div_by_zero", div_by_zero, mDz);
        check("hi", hi, mHi);
        check("lo", lo, mLo);
    end

    // Issue one op at the current falling edge and wait for done.
    task automatic runOp(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eHi, input logic [31:0] eLo,
                         input logic eDz, input int eLat, input bit disturb, input bit withMove);
        int cyc = 0;
        int busyCnt = 0;
        bit seen = 0;
        logic dzSeen = 1'b0;
        op      = o;
        rs_data = a;
        rt_data = b;
        start   = 1'b1;
        mthi    = withMove;
        mtlo    = withMove;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                mthi  = 1'b0;
                mtlo  = 1'b0;
            end
            if (disturb && cyc >= 5 && cyc < 8) begin
                start   = 1'b1;
                op      = 2'b10;
                rs_data = 32'hDEAD_BEEF;
                rt_data = 32'd0;
                mthi    = 1'b1;
                mtlo    = 1'b1;
            end else if (disturb && cyc == 8) begin
                start = 1'b0;
                mthi  = 1'b0;
                mtlo  = 1'b0;
            end
            if (busy) busyCnt++;
            if (done) begin
                seen   = 1;
                dzSeen = div_by_zero;
            end
        end
        check({name, " done seen"}, seen, 1'b1);
        check({name, " latency"}, cyc - 1, eLat);
        check({name, " busy cycles"}, busyCnt, eLat);
        check({name, " dz flag"}, dzSeen, eDz);
        check({name, " HI"}, hi, eHi);
        check({name, " LO"}, lo, eLo);
    endtask

    initial begin
        int doneCnt;
        repeat (3) @(negedge clk);
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);
        check("reset busy", busy, 1'b0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        runOp("MULT 7*-3", 2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, 0, 0);
        runOp("MULTU max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, 0, 0);
        runOp("MULT -1*-1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0, 33, 0, 0);
        runOp("DIV -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 0, 0);
        runOp("DIV 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 1'b0, 33, 0, 0);
        runOp("DIVU 7/2", 2'b11, 32'd7, 32'd2, 32'h1, 32'h3, 1'b0, 33, 0, 0);
        runOp("DIV min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 33, 0, 0);
        runOp("DIVU by 0", 2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1, 1, 0, 0);
        runOp("MULT ignore", 2'b00, 32'd5, 32'd6, 32'h0, 32'd30, 1'b0, 33, 1, 0);

        mthi    = 1'b1;
        rs_data = 32'h0000_1234;
        @(negedge clk);
        mthi = 1'b0;
        check("MTHI hi", hi, 32'h0000_1234);
        check("MTHI lo kept", lo, 32'd30);

        mthi    = 1'b1;
        mtlo    = 1'b1;
        rs_data = 32'h0BAD_F00D;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
        check("MTHI+MTLO hi", hi, 32'h0BAD_F00D);
        check("MTHI+MTLO lo", lo, 32'h0BAD_F00D);

        runOp("start beats move", 2'b01, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0, 33, 0, 1);
        runOp("DIVU after done", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 0, 0);

        op      = 2'b10;
        rs_data = 32'd100;
        rt_data = 32'd7;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort busy", busy, 1'b0);
        check("abort hi", hi, 32'h0);
        check("abort lo", lo, 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        doneCnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
        check("abort no done", doneCnt, 0);

        runOp("MULT 2*3", 2'b00, 32'd2, 32'd3, 32'h0, 32'd6, 1'b0, 33, 0, 0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
